// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e         : arbiter FSM states (CPU owns port / debug completion cycle)
//   WORD_ALIGN_MASK : low byte-address bits that must be zero for a word access
package dmem_arb_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_ACK = 1'b1
    } state_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (CPU port)
// and the debug unit (DBG port). The CPU path is a zero-latency combinational
// mux; debug word accesses are slotted into idle CPU cycles. A saturating
// starvation counter forces a one-cycle CPU stall once debug has been denied
// STARVE_LIMIT cycles in a row.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   cpu_re/we/addr/wdata      : CPU access request
//   cpu_rdata, cpu_stall      : CPU read data (wire of mem_rdata), stall (comb)
//   dbg_req/we/addr/wdata     : debug request, held until dbg_ack
//   dbg_ack/rdata/err         : registered debug completion, read data, misalign error
//   mem_we/re/addr/wdata      : memory port
//   mem_rdata                 : memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_err,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   starve_cnt_q, starve_cnt_d;
    logic                  dbg_err_q, dbg_err_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

    logic cpu_act;
    logic misaligned;
    logic starved;
    logic grant;
    logic dbg_mem;

    assign cpu_act    = cpu_re | cpu_we;
    assign misaligned = (dbg_addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
    assign starved    = starve_cnt_q == CntWidth'(STARVE_LIMIT);
    assign grant      = (state_q == S_CPU) & dbg_req & (~cpu_act | starved);
    // A misaligned grant only produces an error completion; memory stays with the CPU.
    assign dbg_mem    = grant & ~misaligned;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CPU;
            starve_cnt_q <= '0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_err_q    <= dbg_err_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dbg_err_d    = dbg_err_q;
        dbg_rdata_d  = dbg_rdata_q;
        unique case (state_q)
            S_CPU: begin
                if (grant) begin
                    state_d      = S_ACK;
                    starve_cnt_d = '0;
                    dbg_err_d    = misaligned;
                    if (!misaligned && !dbg_we) begin
                        dbg_rdata_d = mem_rdata;
                    end
                end else if (dbg_req && cpu_act) begin
                    if (!starved) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            S_ACK: begin
                // dbg_req is ignored here; the debug unit is dropping it.
                state_d = S_CPU;
            end
            default: state_d = S_CPU;
        endcase
    end

    // Output logic: memory port mux and stall
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_stall = 1'b0;
        if (dbg_mem) begin
            mem_we    = dbg_we;
            mem_re    = ~dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_we ? dbg_wdata : '0;
            cpu_stall = cpu_act;
        end else if (cpu_act) begin
            mem_we    = cpu_we;
            mem_re    = cpu_re;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dbg_ack   = state_q == S_ACK;
    assign dbg_err   = dbg_err_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule
